bnn_input_loader: RTL and testbench

Front-end loader for the binary convolution accelerator. It accepts a valid/ready word stream from the host, writes the 9-bit kernel weight into weight memory, and lays out a sequence of images in input SRAM in the format the accelerator consumes:

- per image: one header word holding the dimension N, followed by N row words;
- after the last image: a 0x00FF terminator.

It then pulses `dut_run`, waits for the accelerator to finish, and reports completion.

---
 rtl/bnn_input_loader_if.sv | 10 +
 rtl/bnn_input_loader.sv | 184 ++++++++++++++++++
 tb/tb_bnn_input_loader.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_input_loader_if.sv
// Host word stream into the BNN input loader (valid/ready with end-of-load marker).
interface bnn_input_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/bnn_input_loader.sv
// Loads the kernel weight and a sequence of images into accelerator memories,
// then launches the accelerator and reports completion.
module bnn_input_loader (
    input  logic                    clk,
    input  logic                    reset_b,
    bnn_input_loader_if.slave       host,
    input  logic                    start,
    output logic [11:0]             ldr_sram_write_address,
    output logic [15:0]             ldr_sram_write_data,
    output logic                    ldr_sram_write_enable,
    output logic [11:0]             ldr_wmem_write_address,
    output logic [15:0]             ldr_wmem_write_data,
    output logic                    ldr_wmem_write_enable,
    output logic                    dut_run,
    input  logic                    dut_busy,
    output logic                    done,
    output logic                    err,
    output logic [7:0]              img_count
);

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;
    localparam int unsigned NW = 5;
    localparam logic [AW:0] PTR_LIMIT = 13'd4095;
    localparam logic [DW-1:0] TERM_WORD = 16'h00FF;
    localparam logic [AW-1:0] WEIGHT_ADDR = 12'd1;

    typedef enum logic [3:0] {
        IDLE, WEIGHT, HEADER, ROWS, TERM, RUN, WAIT_HI, WAIT_LO, DRAIN
    } state_t;

    state_t          state;
    logic            in_ready_q;
    logic [AW-1:0]   ptr;
    logic [NW-1:0]   dim_n;
    logic [NW-1:0]   rows_left;

    logic            acc;
    logic [NW-1:0]   hdr_n;
    logic            hdr_dim_ok;
    logic            hdr_fit;
    logic            hdr_ok;
    logic [DW-1:0]   row_mask;

    assign host.in_ready = in_ready_q;

    // Header decode and row masking for the word currently on the bus.
    always_comb begin
        acc        = host.in_valid & in_ready_q;
        hdr_n      = host.in_data[NW-1:0];
        hdr_dim_ok = (hdr_n == 5'd10) || (hdr_n == 5'd12) || (hdr_n == 5'd16);
        hdr_fit    = ((AW+1)'(ptr) + (AW+1)'(hdr_n) + 13'd1) <= PTR_LIMIT;
        hdr_ok     = hdr_dim_ok && (host.in_data[DW-1:NW] == 11'd0) && hdr_fit && !host.in_last;
        row_mask   = DW'((32'd1 << dim_n) - 32'd1);
    end

    // Load sequencer: all outputs registered, strobes default low each cycle.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state                  <= IDLE;
            in_ready_q             <= 1'b0;
            ptr                    <= '0;
            dim_n                  <= '0;
            rows_left              <= '0;
            ldr_sram_write_address <= '0;
            ldr_sram_write_data    <= '0;
            ldr_sram_write_enable  <= 1'b0;
            ldr_wmem_write_address <= '0;
            ldr_wmem_write_data    <= '0;
            ldr_wmem_write_enable  <= 1'b0;
            dut_run                <= 1'b0;
            done                   <= 1'b0;
            err                    <= 1'b0;
            img_count              <= '0;
        end else begin
            ldr_sram_write_enable <= 1'b0;
            ldr_wmem_write_enable <= 1'b0;
            dut_run               <= 1'b0;
            done                  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !dut_busy) begin
                        err        <= 1'b0;
                        img_count  <= '0;
                        ptr        <= '0;
                        state      <= WEIGHT;
                        in_ready_q <= 1'b1;
                    end
                end
                WEIGHT: begin
                    if (acc) begin
                        if (host.in_last) begin
                            err        <= 1'b1;
                            state      <= IDLE;
                            in_ready_q <= 1'b0;
                        end else begin
                            ldr_wmem_write_enable  <= 1'b1;
                            ldr_wmem_write_address <= WEIGHT_ADDR;
                            ldr_wmem_write_data    <= {7'd0, host.in_data[8:0]};
                            state                  <= HEADER;
                        end
                    end
                end
                HEADER: begin
                    if (acc) begin
                        if (hdr_ok) begin
                            ldr_sram_write_enable  <= 1'b1;
                            ldr_sram_write_address <= ptr;
                            ldr_sram_write_data    <= host.in_data;
                            ptr                    <= ptr + 12'd1;
                            dim_n                  <= hdr_n;
                            rows_left              <= hdr_n;
                            state                  <= ROWS;
                        end else begin
                            err <= 1'b1;
                            if (host.in_last) begin
                                state      <= IDLE;
                                in_ready_q <= 1'b0;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                ROWS: begin
                    if (acc) begin
                        ldr_sram_write_enable  <= 1'b1;
                        ldr_sram_write_address <= ptr;
                        ldr_sram_write_data    <= host.in_data & row_mask;
                        ptr                    <= ptr + 12'd1;
                        rows_left              <= rows_left - 5'd1;
                        if (rows_left == 5'd1) begin
                            if (img_count != 8'hFF) begin
                                img_count <= img_count + 8'd1;
                            end
                            if (host.in_last) begin
                                state      <= TERM;
                                in_ready_q <= 1'b0;
                            end else begin
                                state <= HEADER;
                            end
                        end else if (host.in_last) begin
                            err        <= 1'b1;
                            state      <= IDLE;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                TERM: begin
                    ldr_sram_write_enable  <= 1'b1;
                    ldr_sram_write_address <= ptr;
                    ldr_sram_write_data    <= TERM_WORD;
                    state                  <= RUN;
                end
                RUN: begin
                    dut_run <= 1'b1;
                    state   <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (dut_busy) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!dut_busy) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (acc && host.in_last) begin
                        state      <= IDLE;
                        in_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_input_loader.sv
// Directed bench for bnn_input_loader: memory capture models plus per-scenario tasks.
module tb_bnn_input_loader;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        start = 1'b0;
    logic        dut_busy = 1'b0;
    logic [11:0] sram_addr;
    logic [15:0] sram_data;
    logic        sram_we;
    logic [11:0] wmem_addr;
    logic [15:0] wmem_data;
    logic        wmem_we;
    logic        dut_run;
    logic        done;
    logic        err;
    logic [7:0]  img_count;

    int checks = 0;
    int failures = 0;
    int stall_cnt = 0;
    int sram_wr = 0;
    int wmem_wr = 0;
    int run_cnt = 0;
    int done_cnt = 0;

    logic [15:0] sram [4096];
    logic [15:0] wmem [4096];

    bnn_input_loader_if host();

    bnn_input_loader dut (
        .clk                    (clk),
        .reset_b                (reset_b),
        .host                   (host),
        .start                  (start),
        .ldr_sram_write_address (sram_addr),
        .ldr_sram_write_data    (sram_data),
        .ldr_sram_write_enable  (sram_we),
        .ldr_wmem_write_address (wmem_addr),
        .ldr_wmem_write_data    (wmem_data),
        .ldr_wmem_write_enable  (wmem_we),
        .dut_run                (dut_run),
        .dut_busy               (dut_busy),
        .done                   (done),
        .err                    (err),
        .img_count              (img_count)
    );

    always #5 clk = ~clk;

    // Memory capture and event counting.
    always @(posedge clk) begin
        if (sram_we === 1'b1) begin
            sram[sram_addr] <= sram_data;
            sram_wr <= sram_wr + 1;
        end
        if (wmem_we === 1'b1) begin
            wmem[wmem_addr] <= wmem_data;
            wmem_wr <= wmem_wr + 1;
        end
        if (dut_run === 1'b1) run_cnt <= run_cnt + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one word and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [15:0] d, input logic l);
        int guard;
        guard = 0;
        host.in_valid = 1'b1;
        host.in_data  = d;
        host.in_last  = l;
        while (host.in_ready !== 1'b1 && guard < 50) begin
            stall_cnt++;
            guard++;
            tick();
        end
        if (guard >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout in_ready=%b required=1", host.in_ready);
        end
        tick();
        host.in_valid = 1'b0;
        host.in_last  = 1'b0;
    endtask

    // Wait (bounded) for the run pulse.
    task automatic wait_run(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (dut_run === 1'b1) seen = 1'b1;
            else tick();
        end
    endtask

    // Model the accelerator busy window, then wait (bounded) for done.
    task automatic busy_and_done(input int n, output bit seen);
        seen = 1'b0;
        dut_busy = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        dut_busy = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({host.in_ready, dut_run, done, err, sram_we, wmem_we} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=000000",
                     {host.in_ready, dut_run, done, err, sram_we, wmem_we});
        end
        checks++;
        if ({sram_addr, sram_data, wmem_addr, wmem_data, img_count} !== 64'd0) begin
            failures++;
            $display("FAIL reset_bus got=%h required=0",
                     {sram_addr, sram_data, wmem_addr, wmem_data, img_count});
        end
        reset_b = 1'b1;
        tick();
        checks++;
        if (host.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_ready got=%b required=0", host.in_ready);
        end
    endtask

    task automatic test_single_image();
        bit seen;
        int d0;
        d0 = done_cnt;
        do_start();
        checks++;
        if (host.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready_after_start got=%b required=1", host.in_ready);
        end
        send(16'h01A5, 1'b0);
        checks++;
        if (wmem_we !== 1'b1 || wmem_addr !== 12'd1 || wmem_data !== 16'h01A5) begin
            failures++;
            $display("FAIL single_weight_write we=%b addr=%0d data=%h required 1/1/01a5",
                     wmem_we, wmem_addr, wmem_data);
        end
        send(16'h000A, 1'b0);
        for (int i = 0; i < 10; i++) send(16'(16'h03FF - i), i == 9);
        checks++;
        if (host.in_ready !== 1'b0 || sram_we !== 1'b1 || sram_addr !== 12'd10) begin
            failures++;
            $display("FAIL single_last_row ready=%b we=%b addr=%0d required 0/1/10",
                     host.in_ready, sram_we, sram_addr);
        end
        tick();
        checks++;
        if (sram_we !== 1'b1 || sram_addr !== 12'd11 || sram_data !== 16'h00FF) begin
            failures++;
            $display("FAIL single_term_timing we=%b addr=%0d data=%h required 1/11/00ff",
                     sram_we, sram_addr, sram_data);
        end
        tick();
        checks++;
        if (dut_run !== 1'b1) begin
            failures++;
            $display("FAIL single_run_timing got=%b required=1", dut_run);
        end
        tick();
        checks++;
        if (dut_run !== 1'b0) begin
            failures++;
            $display("FAIL single_run_width got=%b required=0", dut_run);
        end
        busy_and_done(50, seen);
        repeat (3) tick();
        checks++;
        if (!seen || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL single_done seen=%0d pulses=%0d required 1/1", seen, done_cnt - d0);
        end
        checks++;
        if (wmem[1] !== 16'h01A5 || sram[0] !== 16'h000A || sram[11] !== 16'h00FF) begin
            failures++;
            $display("FAIL single_layout wmem1=%h sram0=%h sram11=%h required 01a5/000a/00ff",
                     wmem[1], sram[0], sram[11]);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (sram[i + 1] !== 16'(16'h03FF - i)) begin
                failures++;
                $display("FAIL single_row%0d got=%h required=%h", i, sram[i + 1], 16'(16'h03FF - i));
            end
        end
        checks++;
        if (img_count !== 8'd1) begin
            failures++;
            $display("FAIL single_img_count got=%0d required=1", img_count);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        do_start();
        send(16'h0033, 1'b0);
        stall_cnt = 0;
        send(16'd16, 1'b0);
        for (int i = 0; i < 16; i++) send(16'(16'hA000 + i), 1'b0);
        send(16'd12, 1'b0);
        send(16'hFFFF, 1'b0);
        for (int i = 1; i < 12; i++) send(16'(16'h0100 + i), 1'b0);
        send(16'd10, 1'b0);
        for (int i = 0; i < 10; i++) send(16'(16'h0200 + i), i == 9);
        checks++;
        if (stall_cnt != 0) begin
            failures++;
            $display("FAIL b2b_ready_gaps got=%0d required=0", stall_cnt);
        end
        wait_run(seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL b2b_run got=0 required=1");
        end
        busy_and_done(5, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL b2b_done got=0 required=1");
        end
        checks++;
        if (sram[0] !== 16'd16 || sram[17] !== 16'd12 || sram[30] !== 16'd10 || sram[41] !== 16'h00FF) begin
            failures++;
            $display("FAIL b2b_headers got=%h/%h/%h/%h required 0010/000c/000a/00ff",
                     sram[0], sram[17], sram[30], sram[41]);
        end
        checks++;
        if (sram[16] !== 16'hA00F || sram[29] !== 16'h010B || sram[40] !== 16'h0209) begin
            failures++;
            $display("FAIL b2b_rows got=%h/%h/%h required a00f/010b/0209",
                     sram[16], sram[29], sram[40]);
        end
        checks++;
        if (sram[18] !== 16'h0FFF) begin
            failures++;
            $display("FAIL b2b_row_mask got=%h required=0fff", sram[18]);
        end
        checks++;
        if (img_count !== 8'd3) begin
            failures++;
            $display("FAIL b2b_img_count got=%0d required=3", img_count);
        end
    endtask

    task automatic test_bad_header();
        int s0, r0, d0;
        do_start();
        send(16'h0001, 1'b0);
        s0 = sram_wr;
        r0 = run_cnt;
        d0 = done_cnt;
        send(16'h000B, 1'b0);
        checks++;
        if (err !== 1'b1 || sram_we !== 1'b0) begin
            failures++;
            $display("FAIL badhdr_err err=%b we=%b required 1/0", err, sram_we);
        end
        send(16'h1234, 1'b0);
        send(16'h000A, 1'b0);
        send(16'h5555, 1'b1);
        checks++;
        if (host.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL badhdr_drain_exit ready=%b required=0", host.in_ready);
        end
        repeat (8) tick();
        checks++;
        if (sram_wr != s0 || run_cnt != r0 || done_cnt != d0 || err !== 1'b1) begin
            failures++;
            $display("FAIL badhdr_quiet writes=%0d runs=%0d dones=%0d err=%b required 0/0/0/1",
                     sram_wr - s0, run_cnt - r0, done_cnt - d0, err);
        end
    endtask

    task automatic test_early_last();
        int s0, r0;
        do_start();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL early_start_clears_err got=%b required=0", err);
        end
        send(16'h0002, 1'b0);
        s0 = sram_wr;
        r0 = run_cnt;
        send(16'd16, 1'b0);
        for (int i = 0; i < 5; i++) send(16'(i + 1), i == 4);
        checks++;
        if (err !== 1'b1 || host.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL early_err err=%b ready=%b required 1/0", err, host.in_ready);
        end
        repeat (8) tick();
        checks++;
        if (sram_wr - s0 != 6 || run_cnt != r0) begin
            failures++;
            $display("FAIL early_no_term writes=%0d runs=%0d required 6/0", sram_wr - s0, run_cnt - r0);
        end
        do_start();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL early_restart_err got=%b required=0", err);
        end
        send(16'h0003, 1'b1);
        checks++;
        if (err !== 1'b1 || host.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL weight_last err=%b ready=%b required 1/0", err, host.in_ready);
        end
    endtask

    task automatic test_capacity();
        int s0;
        do_start();
        send(16'h0004, 1'b0);
        s0 = sram_wr;
        for (int k = 0; k < 240; k++) begin
            send(16'd16, 1'b0);
            for (int i = 0; i < 16; i++) send(16'(k * 16 + i), 1'b0);
        end
        checks++;
        if (img_count !== 8'd240 || err !== 1'b0) begin
            failures++;
            $display("FAIL cap_fill img=%0d err=%b required 240/0", img_count, err);
        end
        send(16'd16, 1'b0);
        checks++;
        if (err !== 1'b1 || sram_we !== 1'b0) begin
            failures++;
            $display("FAIL cap_overflow err=%b we=%b required 1/0", err, sram_we);
        end
        send(16'h0000, 1'b1);
        repeat (2) tick();
        checks++;
        if (sram_wr - s0 != 4080 || sram[4063] !== 16'd16 || sram[4079] !== 16'(239 * 16 + 15)) begin
            failures++;
            $display("FAIL cap_layout writes=%0d hdr=%h last=%h required 4080/0010/%h",
                     sram_wr - s0, sram[4063], sram[4079], 16'(239 * 16 + 15));
        end
    endtask

    task automatic test_busy_start();
        int w0;
        w0 = wmem_wr;
        dut_busy = 1'b1;
        do_start();
        tick();
        dut_busy = 1'b0;
        tick();
        checks++;
        if (host.in_ready !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL busy_start_ignored ready=%b err=%b required 0/1", host.in_ready, err);
        end
        host.in_valid = 1'b1;
        host.in_data  = 16'h0055;
        repeat (3) tick();
        host.in_valid = 1'b0;
        checks++;
        if (wmem_wr != w0) begin
            failures++;
            $display("FAIL busy_start_no_write got=%0d required=0", wmem_wr - w0);
        end
    endtask

    task automatic test_reset_mid_rows();
        int r0;
        r0 = run_cnt;
        do_start();
        send(16'h0005, 1'b0);
        send(16'd10, 1'b0);
        for (int i = 0; i < 3; i++) send(16'(16'h0011 + i), 1'b0);
        checks++;
        if (sram_we !== 1'b1 || img_count !== 8'd0) begin
            failures++;
            $display("FAIL rst_mid_pre we=%b img=%0d required 1/0", sram_we, img_count);
        end
        reset_b = 1'b0;
        #1;
        checks++;
        if ({host.in_ready, sram_we, wmem_we, dut_run, done, err} !== 6'b0 ||
            {sram_addr, sram_data, wmem_addr, wmem_data, img_count} !== 64'd0) begin
            failures++;
            $display("FAIL rst_mid_clear ctrl=%b bus=%h required 0/0",
                     {host.in_ready, sram_we, wmem_we, dut_run, done, err},
                     {sram_addr, sram_data, wmem_addr, wmem_data, img_count});
        end
        tick();
        reset_b = 1'b1;
        repeat (6) tick();
        checks++;
        if (host.in_ready !== 1'b0 || run_cnt != r0) begin
            failures++;
            $display("FAIL rst_mid_after ready=%b runs=%0d required 0/0", host.in_ready, run_cnt - r0);
        end
    endtask

    initial begin
        host.in_valid = 1'b0;
        host.in_data  = 16'h0000;
        host.in_last  = 1'b0;
        test_reset();
        test_single_image();
        test_back_to_back();
        test_bad_header();
        test_early_last();
        test_capacity();
        test_busy_start();
        test_reset_mid_rows();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
